// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared widths and FSM state type for the line-oriented data memory
//
// Contents:
//   LINE_W   : width of one stored line in bits
//   ADDR_W   : width of the byte address presented by the cache controller
//   OFFSET_W : number of low address bits that select a byte inside a line
//   state_t  : transaction FSM states (IDLE, WAIT, ACK)
//   line_index(): extracts the line index from a byte address
package data_memory_pkg;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Upper address bits are dropped, so indices wrap modulo the line count.
  function automatic logic [ADDR_W-OFFSET_W-1:0] line_index(
    input logic [ADDR_W-1:0] addr,
    input int                idx_w
  );
    logic [ADDR_W-OFFSET_W-1:0] line;
    logic [ADDR_W-OFFSET_W-1:0] mask;
    line = addr[ADDR_W-1:OFFSET_W];
    mask = (ADDR_W-OFFSET_W)'((64'd1 << idx_w) - 64'd1);
    return line & mask;
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// rtl/data_memory_array.sv - index-addressed line storage with synchronous write and no reset
//
// Ports:
//   clk_i   : clock, writes commit on the rising edge
//   we_i    : write enable for the line at idx_i
//   idx_i   : line index shared by the read and write port
//   wdata_i : line to store
//   rdata_o : current contents of the line at idx_i (combinational read)
module data_memory_array
  import data_memory_pkg::*;
#(
  parameter int MEM_LINES = 512
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [$clog2(MEM_LINES)-1:0] idx_i,
  input  logic [LINE_W-1:0]            wdata_i,
  output logic [LINE_W-1:0]            rdata_o
);

  logic [LINE_W-1:0] mem [MEM_LINES];

  // Contents deliberately survive reset: only a committed write changes a line.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[idx_i];

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - fixed-latency single-outstanding line memory for a cache controller
//
// Optional feature macro: DATA_MEMORY_PROTOCOL_CHECK_EN (adds sticky err_o)
//
// Ports:
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset (array contents are kept)
//   enable_i : request valid
//   write_i  : 1 = line write, 0 = line read
//   addr_i   : byte address, low OFFSET_W bits ignored, index wraps modulo MEM_LINES
//   data_i   : line to write
//   ack_o    : one-cycle completion pulse, LATENCY cycles after the request edge
//   data_o   : line read, updated on read completion and held until the next one
//   err_o    : (macro only) sticky flag for request inputs changing while waiting
module data_memory
  import data_memory_pkg::*;
#(
  parameter int MEM_LINES = 512,
  parameter int LATENCY   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = $clog2(LATENCY);

  // Request edge N enters WAIT; WAIT covers edges N+1..N+LATENCY-1, so the
  // counter starts at LATENCY-2 and the move to ACK happens when it reads 0.
  // The registered ack/data then appear at edge N+LATENCY.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                accept;

  logic [IDX_W-1:0]    idx_q;
  logic                wr_q;
  logic [LINE_W-1:0]   wdata_q;

  logic                array_we;
  logic [LINE_W-1:0]   array_rdata;
  logic [ADDR_W-OFFSET_W-1:0] req_index;

  logic                unused_addr;

  assign req_index   = line_index(addr_i, IDX_W);
  assign unused_addr = ^{addr_i, req_index[ADDR_W-OFFSET_W-1:IDX_W]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
          accept  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        // enable_i is ignored here; the next request can be taken one edge later.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_o   <= (state_q == ACK);
      if ((state_q == ACK) && !wr_q) begin
        data_o <= array_rdata;
      end
    end
  end

  // Request capture; these only matter once a transaction has been accepted.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q   <= req_index[IDX_W-1:0];
      wr_q    <= write_i;
      wdata_q <= data_i;
    end
  end

  // Commit happens on the ACK->IDLE edge, so an async reset in WAIT or ACK
  // drops the state to IDLE before the edge and the write never lands.
  assign array_we = (state_q == ACK) && wr_q;

  data_memory_array #(
    .MEM_LINES (MEM_LINES)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (array_we),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (array_rdata)
  );

`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
  logic [ADDR_W-OFFSET_W-1:0] line_q;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      line_q <= addr_i[ADDR_W-1:OFFSET_W];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if ((state_q == WAIT) &&
                 (!enable_i || (addr_i[ADDR_W-1:OFFSET_W] != line_q))) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed bench with a transaction-level reference model for data_memory
module tb_data_memory;

  localparam int L = 10;
  localparam int N = 512;

  localparam logic [255:0] PA5 = {32{8'hA5}};
  localparam logic [255:0] P1  = {8{32'h1234_5678}};
  localparam logic [255:0] P2  = {8{32'hC0DE_F00D}};
  localparam logic [255:0] P3  = {8{32'hFFFF_0000}};
  localparam logic [255:0] P4  = {4{64'h0F0F_0F0F_F0F0_F0F0}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         wr  = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] din  = '0;
  logic         ack;
  logic [255:0] dout;
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
  logic         err;
`endif

  always #5 clk = ~clk;

  data_memory #(
    .MEM_LINES (N),
    .LATENCY   (L)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (en),
    .write_i  (wr),
    .addr_i   (addr),
    .data_i   (din),
    .ack_o    (ack),
    .data_o   (dout)
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
    ,
    .err_o    (err)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int edge_no = 0;
  int ack_edges[$];

  // Transaction-level reference: one outstanding request, done LATENCY edges
  // after acceptance, the completion edge itself cannot accept a new request.
  logic [255:0] m_mem [N];
  bit           m_known [N];
  bit           m_busy = 1'b0;
  int           m_done;
  bit           m_wr;
  int           m_idx;
  logic [255:0] m_d;
  bit           e_ack = 1'b0;
  logic [255:0] e_data = '0;
  bit           e_known = 1'b0;
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
  bit           e_err = 1'b0;
  logic [26:0]  m_line;
`endif

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic int count_acks(input int lo, input int hi);
    int n = 0;
    foreach (ack_edges[i]) if (ack_edges[i] >= lo && ack_edges[i] <= hi) n++;
    return n;
  endfunction

  function automatic bit has_ack(input int e);
    foreach (ack_edges[i]) if (ack_edges[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      m_busy  = 1'b0;
      e_ack   = 1'b0;
      e_data  = '0;
      e_known = 1'b1;
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
      e_err   = 1'b0;
`endif
    end else begin
      e_ack = 1'b0;
      if (m_busy) begin
        if (edge_no == m_done) begin
          m_busy = 1'b0;
          e_ack  = 1'b1;
          if (m_wr) begin
            m_mem[m_idx]   = m_d;
            m_known[m_idx] = 1'b1;
          end else begin
            e_data  = m_mem[m_idx];
            e_known = m_known[m_idx];
          end
        end
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
        else if (!en || addr[31:5] != m_line) begin
          e_err = 1'b1;
        end
`endif
      end else if (en) begin
        m_busy = 1'b1;
        m_done = edge_no + L;
        m_wr   = wr;
        m_idx  = int'((addr >> 5) % N);
        m_d    = din;
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
        m_line = addr[31:5];
`endif
      end
    end
    #1;
    check("ack_o", ack, e_ack);
    if (e_known) check("data_o", dout, e_data);
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
    check("err_o", err, e_err);
`endif
    if (ack) ack_edges.push_back(edge_no);
  end

  task automatic to_edge(input int e);
    while (edge_no < e) @(negedge clk);
  endtask

  // Holds the request through the wait phase, returns one cycle after the ack cycle.
  task automatic issue(input bit w, input logic [31:0] a, input logic [255:0] d, output int at);
    @(negedge clk);
    en = 1'b1; wr = w; addr = a; din = d;
    at = edge_no + 1;
    to_edge(at + L - 1);
    en = 1'b0;
    to_edge(at + L + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at edge %0d", edge_no);
    $fatal(1);
  end

  initial begin
    int at;
    int s;

    // Reset state
    to_edge(3);
    check("reset_ack", ack, 1'b0);
    check("reset_data", dout, 256'd0);
    rst = 1'b0;

    // Write then read back; exactly one ack at request edge + L
    issue(1'b1, 32'h0000_0400, PA5, at);
    check("wr_ack_edge", has_ack(at + L), 1'b1);
    check("wr_ack_count", count_acks(at, at + L + 1), 1);
    check("wr_keeps_data_o", dout, 256'd0);
    issue(1'b0, 32'h0000_0400, 256'd0, at);
    check("rd_ack_edge", has_ack(at + L), 1'b1);
    check("rd_data", dout, PA5);

    // Offset ignored and index wrap
    issue(1'b0, 32'h0000_041F, 256'd0, at);
    check("rd_offset", dout, PA5);
    issue(1'b0, 32'h0000_4400, 256'd0, at);
    check("rd_wrap", dout, PA5);

    // Write to another line leaves data_o alone
    issue(1'b1, 32'h0000_00A0, P1, at);
    check("wr_no_data_change", dout, PA5);
    issue(1'b0, 32'h0000_00A0, 256'd0, at);
    check("rd_line5", dout, P1);

    // Enable held high: one ack per L+1 cycles
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = 32'h0000_0400;
    s = edge_no + 1;
    to_edge(s + 2 * L + 12);
    en = 1'b0;
    to_edge(s + 3 * L + 6);
    check("hold_ack_count", count_acks(s, s + 3 * L + 6), 3);
    check("hold_ack_1", has_ack(s + L), 1'b1);
    check("hold_ack_2", has_ack(s + 2 * L + 1), 1'b1);
    check("hold_ack_3", has_ack(s + 3 * L + 2), 1'b1);

    // Inputs changed mid-read: latched read still served, no write happens
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = 32'h0000_00A0; din = 256'd0;
    at = edge_no + 1;
    to_edge(at + 4);
    wr = 1'b1; addr = 32'h0000_0400; din = P3;
    to_edge(at + L - 1);
    en = 1'b0; wr = 1'b0;
    to_edge(at + L + 1);
    check("chg_ack_edge", has_ack(at + L), 1'b1);
    check("chg_rd_data", dout, P1);
    issue(1'b0, 32'h0000_0400, 256'd0, at);
    check("chg_no_write", dout, PA5);

    // Reset in the middle of a write: no ack, no write, data_o cleared
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h0000_00A0; din = P4;
    at = edge_no + 1;
    to_edge(at + 5);
    rst = 1'b1; en = 1'b0; wr = 1'b0;
    to_edge(at + 7);
    rst = 1'b0;
    to_edge(at + L + 3);
    check("rst_no_ack", count_acks(at, at + L + 3), 0);
    check("rst_data_zero", dout, 256'd0);
    issue(1'b0, 32'h0000_00A0, 256'd0, at);
    check("rst_after_ack", has_ack(at + L), 1'b1);
    check("rst_old_line", dout, P1);

    // Enable dropped during wait
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = 32'h0000_0400;
    at = edge_no + 1;
    to_edge(at + 2);
    en = 1'b0;
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
    check("err_before_drop", err, 1'b0);
    to_edge(at + 3);
    check("err_after_drop", err, 1'b1);
`endif
    to_edge(at + L + 1);
    check("drop_ack_edge", has_ack(at + L), 1'b1);
`ifdef DATA_MEMORY_PROTOCOL_CHECK_EN
    check("err_sticky", err, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    to_edge(edge_no + 2);
    rst = 1'b0;
    check("err_cleared", err, 1'b0);
`endif

    // High address bits alias onto line 32
    issue(1'b1, 32'hFFFF_C400, P2, at);
    issue(1'b0, 32'h0000_0400, 256'd0, at);
    check("alias_high_bits", dout, P2);

    to_edge(edge_no + 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter: MEM_LINES, 512, number of 256-bit lines stored (power of two, >=2).
REQ-002 Parameter: LATENCY, 10, cycles from request sample to ack (>=2).
REQ-003 Port: clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_i  input  1  reset, asynchronous, active-high.
REQ-005 Port: enable_i  input  1  request valid from cache controller.
REQ-006 Port: write_i  input  1  1 = line write, 0 = line read; qualified by enable_i.
REQ-007 Port: addr_i  input  32  byte address; bits [4:0] ignored.
REQ-008 Port: data_i  input  256  write line data.
REQ-009 Port: ack_o  output  1  one-cycle completion pulse.
REQ-010 Port: data_o  output  256  read line data, valid while ack_o high after a read.

Function
REQ-011 The block SHALL implement states IDLE, WAIT, ACK.
REQ-012 In IDLE, on a rising edge with enable_i=1, the block SHALL latch line index addr_i[5+log2(MEM_LINES)-1:5], write_i and data_i, load the latency counter, and enter WAIT.
REQ-013 Address bits above the index SHALL be ignored (line index wraps modulo MEM_LINES).
REQ-014 Latched values SHALL be used for the whole transaction; input changes during WAIT/ACK SHALL have no effect.
REQ-015 For a request sampled at edge N, ack_o SHALL be 1 for exactly the cycle between edges N+LATENCY and N+LATENCY+1, and 0 otherwise.
REQ-016 A latched write SHALL commit data to the array at edge N+LATENCY; the stored line SHALL be readable by any later request.
REQ-017 For a latched read, data_o SHALL present the addressed line during the ack cycle and SHALL hold that value until the next read ack.
REQ-018 A write SHALL not change data_o.
REQ-019 From ACK the block SHALL return to IDLE at the next edge unconditionally; enable_i sampled in ACK SHALL be ignored (minimum request spacing LATENCY+1 cycles).
REQ-020 A read following a write to the same line SHALL return the written data.
REQ-021 Only one transaction SHALL be outstanding; no queuing.

Reset
REQ-022 While rst_i=1: state=IDLE, counter=0, ack_o=0, data_o=0, regardless of clock.
REQ-023 Reset during WAIT SHALL abort the transaction with no array write and no ack.
REQ-024 Array contents SHALL not be cleared by reset.

Configuration
REQ-025 Macro DATA_MEMORY_PROTOCOL_CHECK_EN defined: block SHALL add output err_o (1 bit) set when, in WAIT, enable_i=0 or addr_i[31:5] differs from latched value; err_o sticky until reset, reset value 0.
REQ-026 Macro undefined: err_o SHALL be absent and such violations silently ignored; all other behaviour identical.

Structure
REQ-027 Package data_memory_pkg SHALL hold the state enumeration, LINE_W=256, ADDR_W=32, OFFSET_W=5.
REQ-028 Storage SHALL be a sub-module data_memory_array (synchronous-write, index-addressed line array, no reset); FSM and counter SHALL stay in data_memory.

Verification (LATENCY=10, MEM_LINES=512)
REQ-029 Write 0xA5..A5 to addr 0x0000_0400 at edge 0 -> ack_o high only in cycle after edge 10; later read of 0x0000_0400 returns 0xA5..A5.
REQ-030 Read addr 0x0000_041F -> same line as 0x0000_0400 (offset ignored); read 0x0000_4400 -> aliases line 32 (wrap).
REQ-031 Hold enable_i=1 continuously -> acks at cycles 10, 21, 32 (one per LATENCY+1), none in between.
REQ-032 Change addr_i/write_i/data_i at cycle 5 of a read -> response uses values latched at edge 0, no write occurs.
REQ-033 Assert rst_i at cycle 6 of a write -> ack_o never pulses, line keeps old contents, data_o=0; new request after release completes normally.
REQ-034 With DATA_MEMORY_PROTOCOL_CHECK_EN, drop enable_i at cycle 3 -> err_o=1 from next edge until reset; without macro, transaction still acks at cycle 10.
